icache_direct: RTL

- Direct-mapped, read-only instruction cache between the fetch stage and the unified memory's instruction port.
- Each cycle it serves one 32-bit instruction from a 20-bit byte PC.
- On a miss it stalls fetch, issues a single-cycle line request to memory, waits for the 128-bit line, installs it, and resumes.
- It also supports a full invalidate (flush) for self-modifying code and fence handling.

---
 rtl/icache_direct.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache with single outstanding line refill and full flush.
// Optional hit/miss counters are compiled in when ICACHE_STATS_EN is defined.
module icache_direct #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned LINE_BITS      = 16,
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned INDEX_BITS     = 6
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           F_req,
  input  logic [LINE_BITS+3:0]           F_pc,
  output logic [XLEN-1:0]                F_inst,
  output logic                           F_stall,
  input  logic                           Ic_flush,
  output logic                           Ic_mem_req,
  output logic [LINE_BITS-1:0]           Ic_mem_addr,
  input  logic [XLEN*WORDS_PER_LINE-1:0] F_mem_inst,
  input  logic                           F_mem_valid
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]                    Ic_hit_cnt,
  output logic [31:0]                    Ic_miss_cnt
`endif
);

  localparam int unsigned TagBits = LINE_BITS - INDEX_BITS;
  localparam int unsigned Sets    = 1 << INDEX_BITS;

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e                        state_q, state_d;
  logic [Sets-1:0]               valid_q, valid_d;
  logic [LINE_BITS-1:0]          miss_line_q, miss_line_d;
  logic                          drop_q, drop_d;
  logic [TagBits-1:0]            tag_q  [Sets];
  logic [XLEN*WORDS_PER_LINE-1:0] data_q [Sets];

  logic [INDEX_BITS-1:0]         idx, fill_idx;
  logic [TagBits-1:0]            pc_tag, fill_tag;
  logic [1:0]                    word;
  logic                          hit, fill;
  logic [XLEN*WORDS_PER_LINE-1:0] line_rd;
  logic                          unused_pc;

  assign idx       = F_pc[4 +: INDEX_BITS];
  assign pc_tag    = F_pc[LINE_BITS+3 -: TagBits];
  assign word      = F_pc[3:2];
  assign unused_pc = ^F_pc[1:0];
  assign fill_idx  = miss_line_q[INDEX_BITS-1:0];
  assign fill_tag  = miss_line_q[LINE_BITS-1 -: TagBits];

  assign hit         = (state_q == StIdle) && valid_q[idx] && (tag_q[idx] == pc_tag);
  assign F_stall     = F_req && !hit;
  assign Ic_mem_req  = (state_q == StReq);
  assign Ic_mem_addr = miss_line_q;

  always_comb begin
    line_rd = data_q[idx];
    F_inst  = '0;
    for (int w = 0; w < WORDS_PER_LINE; w++) begin
      if (word == w[1:0]) F_inst = line_rd[w*XLEN +: XLEN];
    end
  end

  always_comb begin
    state_d     = state_q;
    miss_line_d = miss_line_q;
    drop_d      = drop_q;
    valid_d     = valid_q;
    fill        = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A flush in the same cycle as a miss wins; the miss retries next cycle.
        if (F_req && !hit && !Ic_flush) begin
          miss_line_d = F_pc[LINE_BITS+3:4];
          state_d     = StReq;
        end
      end
      StReq: begin
        if (Ic_flush) drop_d = 1'b1;
        state_d = StWait;
      end
      StWait: begin
        if (Ic_flush) drop_d = 1'b1;
        if (F_mem_valid) begin
          fill    = !drop_q;
          drop_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (fill) valid_d[fill_idx] = 1'b1;
    if (Ic_flush) valid_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      valid_q     <= '0;
      miss_line_q <= '0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      miss_line_q <= miss_line_d;
      drop_q      <= drop_d;
    end
  end

  // Tag/data arrays carry no reset; valid bits guard them.
  always_ff @(posedge clk) begin
    if (fill && !rst) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= F_mem_inst;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  logic        miss_start;

  assign miss_start = (state_q == StIdle) && (state_d == StReq);

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (F_req && !F_stall) hit_cnt_q <= hit_cnt_q + 32'd1;
      if (miss_start) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign Ic_hit_cnt  = hit_cnt_q;
  assign Ic_miss_cnt = miss_cnt_q;
`endif

endmodule
